// File: rtl/move_step_unit.sv
// Coordinate stepper (+1/-1 on a selected axis with grid-exit detection)
// plus a small loadable direction counter with terminal count.
module move_step_unit #(
    parameter int unsigned COORD_W = 4,
    parameter int unsigned CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic               adder_sel,
    input  logic               inc_dec_sel,
    input  logic               ld_counter,
    input  logic               inc_counter,
    input  logic [CNT_W-1:0]   counter_ld_val,
    output logic [COORD_W-1:0] adder_res,
    output logic               cout,
    output logic               out_of_range,
    output logic [CNT_W-1:0]   counter_val,
    output logic               co
);

    localparam int unsigned SUM_W = COORD_W + 1;

    logic [COORD_W-1:0] operand;
    logic [COORD_W-1:0] step;
    logic [SUM_W-1:0]   sum;

    // Decrement is an add of all-ones; carry set means no borrow occurred.
    always_comb begin
        operand      = adder_sel ? cur_x : cur_y;
        step         = inc_dec_sel ? COORD_W'(1) : {COORD_W{1'b1}};
        sum          = SUM_W'(operand) + SUM_W'(step);
        adder_res    = sum[COORD_W-1:0];
        cout         = sum[COORD_W];
        out_of_range = inc_dec_sel ? cout : ~cout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_val <= '0;
        end else if (ld_counter) begin
            counter_val <= counter_ld_val;
        end else if (inc_counter) begin
            counter_val <= counter_val + CNT_W'(1);
        end
    end

    assign co = &counter_val;

endmodule

// File: tb/tb_move_step_unit.sv
// Directed self-checking bench for move_step_unit.
module tb_move_step_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cur_x;
    logic [3:0] cur_y;
    logic       adder_sel;
    logic       inc_dec_sel;
    logic       ld_counter;
    logic       inc_counter;
    logic [1:0] counter_ld_val;
    logic [3:0] adder_res;
    logic       cout;
    logic       out_of_range;
    logic [1:0] counter_val;
    logic       co;

    int checks = 0;
    int errors = 0;

    move_step_unit #(.COORD_W(4), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .cur_x(cur_x),
        .cur_y(cur_y),
        .adder_sel(adder_sel),
        .inc_dec_sel(inc_dec_sel),
        .ld_counter(ld_counter),
        .inc_counter(inc_counter),
        .counter_ld_val(counter_ld_val),
        .adder_res(adder_res),
        .cout(cout),
        .out_of_range(out_of_range),
        .counter_val(counter_val),
        .co(co)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_counter = 1'b1; inc_counter = 1'b1; counter_ld_val = 2'd3;
        tick();
        checks++;
        if (counter_val !== 2'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", counter_val);
        end
        checks++;
        if (co !== 1'b0) begin
            errors++; $display("FAIL reset_co: got %b want 0", co);
        end
        rst = 1'b0; ld_counter = 1'b0; inc_counter = 1'b0;
    endtask

    task automatic test_adder_inc();
        cur_x = 4'd5; cur_y = 4'd9; adder_sel = 1'b1; inc_dec_sel = 1'b1;
        #1;
        checks++;
        if ({cout, out_of_range, adder_res} !== {1'b0, 1'b0, 4'd6}) begin
            errors++; $display("FAIL inc_x5: got c=%b oor=%b res=%0d want c=0 oor=0 res=6", cout, out_of_range, adder_res);
        end
        cur_x = 4'd3; cur_y = 4'd15; adder_sel = 1'b0; inc_dec_sel = 1'b1;
        #1;
        checks++;
        if ({cout, out_of_range, adder_res} !== {1'b1, 1'b1, 4'd0}) begin
            errors++; $display("FAIL inc_y15: got c=%b oor=%b res=%0d want c=1 oor=1 res=0", cout, out_of_range, adder_res);
        end
    endtask

    task automatic test_adder_dec();
        cur_x = 4'd0; cur_y = 4'd4; adder_sel = 1'b1; inc_dec_sel = 1'b0;
        #1;
        checks++;
        if ({cout, out_of_range, adder_res} !== {1'b0, 1'b1, 4'd15}) begin
            errors++; $display("FAIL dec_x0: got c=%b oor=%b res=%0d want c=0 oor=1 res=15", cout, out_of_range, adder_res);
        end
        cur_x = 4'd7;
        #1;
        checks++;
        if ({cout, out_of_range, adder_res} !== {1'b1, 1'b0, 4'd6}) begin
            errors++; $display("FAIL dec_x7: got c=%b oor=%b res=%0d want c=1 oor=0 res=6", cout, out_of_range, adder_res);
        end
        cur_x = 4'd2; cur_y = 4'd8; adder_sel = 1'b0;
        #1;
        checks++;
        if ({cout, out_of_range, adder_res} !== {1'b1, 1'b0, 4'd7}) begin
            errors++; $display("FAIL dec_y8: got c=%b oor=%b res=%0d want c=1 oor=0 res=7", cout, out_of_range, adder_res);
        end
    endtask

    task automatic test_counter_inc();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (counter_val !== 2'd0 || co !== 1'b0) begin
            errors++; $display("FAIL cnt_start: got cnt=%0d co=%b want cnt=0 co=0", counter_val, co);
        end
        inc_counter = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (counter_val !== exp_seq[i] || co !== (exp_seq[i] == 2'd3)) begin
                errors++;
                $display("FAIL cnt_inc%0d: got cnt=%0d co=%b want cnt=%0d co=%b",
                         i, counter_val, co, exp_seq[i], exp_seq[i] == 2'd3);
            end
        end
        inc_counter = 1'b0;
    endtask

    task automatic test_load_priority();
        ld_counter = 1'b1; inc_counter = 1'b1; counter_ld_val = 2'd2;
        tick();
        checks++;
        if (counter_val !== 2'd2) begin
            errors++; $display("FAIL ld_over_inc: got %0d want 2", counter_val);
        end
        rst = 1'b1; counter_ld_val = 2'd3;
        cur_x = 4'd15; adder_sel = 1'b1; inc_dec_sel = 1'b1;
        tick();
        checks++;
        if (counter_val !== 2'd0 || co !== 1'b0) begin
            errors++; $display("FAIL rst_over_ld: got cnt=%0d co=%b want cnt=0 co=0", counter_val, co);
        end
        checks++;
        if ({cout, out_of_range, adder_res} !== {1'b1, 1'b1, 4'd0}) begin
            errors++; $display("FAIL adder_in_rst: got c=%b oor=%b res=%0d want c=1 oor=1 res=0", cout, out_of_range, adder_res);
        end
        rst = 1'b0; ld_counter = 1'b0; inc_counter = 1'b0;
    endtask

    task automatic test_hold();
        ld_counter = 1'b1; counter_ld_val = 2'd1;
        tick();
        ld_counter = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (counter_val !== 2'd1 || co !== 1'b0) begin
                errors++; $display("FAIL hold%0d: got cnt=%0d co=%b want cnt=1 co=0", i, counter_val, co);
            end
        end
    endtask

    task automatic test_back_to_back();
        ld_counter = 1'b1; counter_ld_val = 2'd3;
        tick();
        ld_counter = 1'b0; inc_counter = 1'b1;
        checks++;
        if (counter_val !== 2'd3 || co !== 1'b1) begin
            errors++; $display("FAIL ld3: got cnt=%0d co=%b want cnt=3 co=1", counter_val, co);
        end
        tick();
        inc_counter = 1'b0;
        checks++;
        if (counter_val !== 2'd0 || co !== 1'b0) begin
            errors++; $display("FAIL wrap_after_ld: got cnt=%0d co=%b want cnt=0 co=0", counter_val, co);
        end
    endtask

    initial begin
        rst = 1'b0; ld_counter = 1'b0; inc_counter = 1'b0; counter_ld_val = 2'd0;
        cur_x = 4'd0; cur_y = 4'd0; adder_sel = 1'b0; inc_dec_sel = 1'b0;
        @(negedge clk);
        test_reset();
        test_adder_inc();
        test_adder_dec();
        test_counter_inc();
        test_load_priority();
        test_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
